a5_stack_unit: RTL and testbench
================================

Name: a5_stack_unit

Overview:
- Hardware LIFO data stack for the 16-bit processor. It sits directly downstream of the ALU result demux.
- It captures the demux's stack_push_a word on push and returns words to the datapath on pop.
- It also supplies a registered top-of-stack view and status/error flags to the control unit.

Parameters:
DATA_W, 16, word width (matches ALU/demux data path)
DEPTH, 16, number of stack entries; must be a power of two, at least 2
PTR_W, 4, log2(DEPTH); pointer width (count uses PTR_W+1 bits)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
stack_push_a  input  DATA_W  word to push (driven by ALU result demux)
push  input  1  push request, sampled on rising edge of clk
pop  input  1  pop request, sampled on rising edge of clk
clr_err  input  1  synchronous clear of sticky error flags
stack_pop_a  output  DATA_W  registered word returned by the last successful pop
pop_valid  output  1  one-cycle pulse: stack_pop_a updated this cycle
tos  output  DATA_W  current top-of-stack word (registered, 0 when empty)
count  output  PTR_W+1  number of valid entries, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
overflow  output  1  sticky: push attempted while full with no pop
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, rst=1):
  - count=0, stack_pop_a=0, tos=0, pop_valid=0, overflow=0, underflow=0.
  - empty=1, full=0.
  - Memory contents are don't-care and not cleared.
- Storage: DEPTH x DATA_W register array. The write pointer equals count; the top entry is at index count-1.
- Push only (push=1, pop=0):
  - If not full: mem[count] <= stack_push_a, count+1, tos <= stack_push_a next cycle.
  - If full: no write, count unchanged, overflow <= 1.
- Pop only (push=0, pop=1):
  - If not empty: stack_pop_a <= mem[count-1], pop_valid=1 for one cycle, count-1. tos becomes mem[count-2], or 0 if the stack becomes empty.
  - If empty: stack_pop_a holds, pop_valid=0, underflow <= 1.
- Push and pop in the same cycle:
  - If not empty: stack_pop_a <= old top, pop_valid=1, old top slot overwritten with stack_push_a, count unchanged, tos <= stack_push_a. This is legal when full; no overflow.
  - If empty: bypass. stack_pop_a <= stack_push_a, pop_valid=1, count stays 0, tos stays 0, no underflow.
- Neither request: all state holds; pop_valid=0.
- Latency:
  - Push is visible on tos and count one cycle after the request edge.
  - Popped data is on stack_pop_a one cycle after the request edge, qualified by pop_valid.
  - Back-to-back pushes and pops every cycle are supported with no bubbles.
- empty and full are decoded from registered count, so they are glitch-free and valid one cycle after each update.
- Error flags:
  - Flags are sticky until clr_err=1.
  - clr_err has priority over a same-cycle new error: the flag reads 0 after that edge.
  - Errors never corrupt count or memory.
- count never wraps: it saturates at 0 and DEPTH through the full/empty guards.
- Reset asserted mid-operation aborts any in-flight request immediately; outputs go to their reset values without waiting for clk.

Test Plan:
- Reset then idle: rst pulse -> count=0, empty=1, full=0, tos=0, stack_pop_a=0, overflow=underflow=0.
- LIFO order: push 16'h1111, 16'h2222, 16'h3333 on consecutive cycles, then 3 pops -> stack_pop_a = 3333, 2222, 1111 with pop_valid each cycle; count 3->0; empty=1; tos = 2222, 1111, 0.
- Full and overflow: push 16 words 16'h0000..16'h000F -> full=1, count=16, tos=000F. A 17th push of 16'hDEAD -> overflow=1, count=16, tos=000F. Pop -> 000F.
- Underflow and clear: on an empty stack, pop -> underflow=1, pop_valid=0, stack_pop_a unchanged. clr_err=1 -> underflow=0. clr_err with a simultaneous empty pop -> underflow=0.
- Simultaneous push/pop:
  - Stack holds A5A5 then 5A5A; push=pop=1 with 16'hBEEF -> stack_pop_a=5A5A, count=2, tos=BEEF.
  - When full, the same operation gives no overflow.
  - When empty, stack_pop_a=BEEF, count=0.
- Async reset mid-stream: assert rst between clock edges after 5 pushes -> outputs clear immediately. After release, the next pop sets underflow=1.

Source files
------------

// File: rtl/a5_stack_unit.sv
// a5_stack_unit: LIFO data stack for the 16-bit processor datapath.
// It pushes words from the ALU result demux and pops them back to the datapath.
// It keeps a registered top-of-stack copy so the control unit can read the top
// without a memory read, and it reports occupancy and sticky error flags.
module a5_stack_unit #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] stack_push_a,
  input  logic              push,
  input  logic              pop,
  input  logic              clr_err,
  output logic [DATA_W-1:0] stack_pop_a,
  output logic              pop_valid,
  output logic [DATA_W-1:0] tos,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  // Resolved operation for this cycle. Error cases are kept separate so the
  // flag logic and the data path both key off a single decode.
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_PUSH_FULL,
    OP_POP,
    OP_POP_EMPTY,
    OP_SWAP,
    OP_BYPASS
  } op_e;

  op_e               op;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  top_idx;
  logic [PTR_W-1:0]  below_idx;
  logic [DATA_W-1:0] pop_tos;
  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;

  // The write pointer is the count itself. When the stack is full the low bits
  // wrap to 0, but no push-only write happens then. The top and below-top
  // indices wrap the same way, so the arithmetic stays modulo DEPTH.
  assign wr_idx    = count[PTR_W-1:0];
  assign top_idx   = wr_idx - 1'b1;
  assign below_idx = wr_idx - PTR_W'(2);

  // Status flags are decoded from the registered count, so they cannot glitch.
  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);

  // Decode the request pair against the current occupancy.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    op = OP_IDLE;
    case ({push, pop})
      2'b10:   op = full  ? OP_PUSH_FULL : OP_PUSH;
      2'b01:   op = empty ? OP_POP_EMPTY : OP_POP;
      2'b11:   op = empty ? OP_BYPASS    : OP_SWAP;
      default: op = OP_IDLE;
    endcase
  end

  // On a pop, the word below the current top becomes the new top.
  // When the last entry is popped, the new top is 0.
  always_comb begin
    pop_tos = '0;
    if (count != PTR_W'(1) + (PTR_W+1)'(0))
      pop_tos = mem[below_idx];
  end

  // Select the memory write for this cycle. A push-only request appends at the
  // count. A push with pop replaces the current top in place.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_idx;
    if (!rst) begin
      if (op == OP_PUSH) begin
        mem_we    = 1'b1;
        mem_waddr = wr_idx;
      end else if (op == OP_SWAP) begin
        mem_we    = 1'b1;
        mem_waddr = top_idx;
      end
    end
  end

  // Storage array write port.
  // NOTE: the storage array has no reset, because its contents are don't-care until pushed. This also keeps it mappable to plain register banks or RAM.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= stack_push_a;
  end

  // Occupancy, top-of-stack copy and pop return register.
  // Because tos always mirrors mem[count-1], a pop returns tos directly and no
  // memory read is needed.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only. Every register then samples pre-edge values, whatever the statement order.
    if (rst) begin
      count       <= '0;
      tos         <= '0;
      stack_pop_a <= '0;
      pop_valid   <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      case (op)
        OP_PUSH: begin
          count <= count + 1'b1;
          tos   <= stack_push_a;
        end
        OP_POP: begin
          count       <= count - 1'b1;
          stack_pop_a <= tos;
          pop_valid   <= 1'b1;
          tos         <= pop_tos;
        end
        OP_SWAP: begin
          stack_pop_a <= tos;
          pop_valid   <= 1'b1;
          tos         <= stack_push_a;
        end
        OP_BYPASS: begin
          stack_pop_a <= stack_push_a;
          pop_valid   <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky error flags. A clear wins over an error raised in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr_err) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (op == OP_PUSH_FULL)
        overflow <= 1'b1;
      if (op == OP_POP_EMPTY)
        underflow <= 1'b1;
    end
  end

  // Structural invariants: occupancy stays in range, and an empty stack shows a zero top.
  a_count_range : assert property (@(posedge clk) disable iff (rst) count <= DEPTH_CNT);
  a_empty_tos   : assert property (@(posedge clk) disable iff (rst) empty |-> (tos == '0));

endmodule

// File: tb/tb_a5_stack_unit.sv
// Self-checking bench for a5_stack_unit.
// It runs a directed vector table, hand-written full/overflow and async-reset
// sequences, and randomized traffic checked against a queue-based model.
module tb_a5_stack_unit;

  localparam int DW = 16;
  localparam int DP = 16;

  logic          clk;
  logic          rst;
  logic [DW-1:0] stack_push_a;
  logic          push;
  logic          pop;
  logic          clr_err;
  logic [DW-1:0] stack_pop_a;
  logic          pop_valid;
  logic [DW-1:0] tos;
  logic [4:0]    count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  int n_vec  = 0;
  int n_miss = 0;

  a5_stack_unit #(.DATA_W(DW), .DEPTH(DP), .PTR_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .stack_push_a (stack_push_a),
    .push         (push),
    .pop          (pop),
    .clr_err      (clr_err),
    .stack_pop_a  (stack_pop_a),
    .pop_valid    (pop_valid),
    .tos          (tos),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          push;
    logic          pop;
    logic          clr;
    logic [DW-1:0] d;
    int            c;
    logic [DW-1:0] tos;
    logic [DW-1:0] pa;
    logic          pv;
    logic          ovf;
    logic          udf;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int c, input logic [DW-1:0] t,
                           input logic [DW-1:0] pa, input logic pv, input logic ovf,
                           input logic udf);
    check({name, ".count"}, 32'(count), 32'(c));
    check({name, ".tos"}, 32'(tos), 32'(t));
    check({name, ".pop_a"}, 32'(stack_pop_a), 32'(pa));
    check({name, ".pop_valid"}, 32'(pop_valid), 32'(pv));
    check({name, ".overflow"}, 32'(overflow), 32'(ovf));
    check({name, ".underflow"}, 32'(underflow), 32'(udf));
    check({name, ".empty"}, 32'(empty), 32'(c == 0));
    check({name, ".full"}, 32'(full), 32'(c == DP));
  endtask

  // Drive one request, let one rising edge take it, then sample 1 time unit after that edge.
  task automatic apply(input logic p, input logic q, input logic c, input logic [DW-1:0] d);
    push = p; pop = q; clr_err = c; stack_push_a = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input logic p, input logic q, input logic c,
                     input logic [DW-1:0] d, input int cnt, input logic [DW-1:0] t,
                     input logic [DW-1:0] pa, input logic pv, input logic ovf,
                     input logic udf);
    vec_t v;
    v.name = n; v.push = p; v.pop = q; v.clr = c; v.d = d; v.c = cnt;
    v.tos = t; v.pa = pa; v.pv = pv; v.ovf = ovf; v.udf = udf;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    push = 0; pop = 0; clr_err = 0; stack_push_a = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Reference model state. The stack is a queue whose back is the top of stack.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_pa;
  logic          m_pv;
  logic          m_ovf;
  logic          m_udf;

  task automatic model_step(input logic p, input logic q, input logic c, input logic [DW-1:0] d);
    logic e_ovf = 1'b0;
    logic e_udf = 1'b0;
    m_pv = 1'b0;
    if (p && q) begin
      m_pv = 1'b1;
      if (m_q.size() > 0) begin
        m_pa = m_q[$];
        m_q[m_q.size()-1] = d;
      end else begin
        m_pa = d;
      end
    end else if (p) begin
      if (m_q.size() < DP) m_q.push_back(d);
      else e_ovf = 1'b1;
    end else if (q) begin
      if (m_q.size() > 0) begin
        m_pa = m_q.pop_back();
        m_pv = 1'b1;
      end else begin
        e_udf = 1'b1;
      end
    end
    if (c) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      m_ovf = m_ovf | e_ovf;
      m_udf = m_udf | e_udf;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] mt;
    rst = 1'b1;
    push = 0; pop = 0; clr_err = 0; stack_push_a = '0;

    // Check the reset state while reset is still asserted, then again after release.
    #3;
    check_all("reset_async", 0, 16'h0, 16'h0, 0, 0, 0);
    do_reset();
    check_all("reset_idle", 0, 16'h0, 16'h0, 0, 0, 0);

    // Directed table. Each row is: inputs, then the expected state after the edge.
    add("idle",        0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0);
    add("push1111",    1, 0, 0, 16'h1111, 1, 16'h1111, 16'h0000, 0, 0, 0);
    add("push2222",    1, 0, 0, 16'h2222, 2, 16'h2222, 16'h0000, 0, 0, 0);
    add("push3333",    1, 0, 0, 16'h3333, 3, 16'h3333, 16'h0000, 0, 0, 0);
    add("pop3333",     0, 1, 0, 16'h0000, 2, 16'h2222, 16'h3333, 1, 0, 0);
    add("pop2222",     0, 1, 0, 16'h0000, 1, 16'h1111, 16'h2222, 1, 0, 0);
    add("pop1111",     0, 1, 0, 16'h0000, 0, 16'h0000, 16'h1111, 1, 0, 0);
    add("pop_empty",   0, 1, 0, 16'h0000, 0, 16'h0000, 16'h1111, 0, 0, 1);
    add("udf_hold",    0, 0, 0, 16'h0000, 0, 16'h0000, 16'h1111, 0, 0, 1);
    add("clr_err",     0, 0, 1, 16'h0000, 0, 16'h0000, 16'h1111, 0, 0, 0);
    add("pop_empty2",  0, 1, 0, 16'h0000, 0, 16'h0000, 16'h1111, 0, 0, 1);
    add("clr_vs_udf",  0, 1, 1, 16'h0000, 0, 16'h0000, 16'h1111, 0, 0, 0);
    add("pushA5A5",    1, 0, 0, 16'hA5A5, 1, 16'hA5A5, 16'h1111, 0, 0, 0);
    add("push5A5A",    1, 0, 0, 16'h5A5A, 2, 16'h5A5A, 16'h1111, 0, 0, 0);
    add("swapBEEF",    1, 1, 0, 16'hBEEF, 2, 16'hBEEF, 16'h5A5A, 1, 0, 0);
    add("popBEEF",     0, 1, 0, 16'h0000, 1, 16'hA5A5, 16'hBEEF, 1, 0, 0);
    add("popA5A5",     0, 1, 0, 16'h0000, 0, 16'h0000, 16'hA5A5, 1, 0, 0);
    add("bypassBEEF",  1, 1, 0, 16'hBEEF, 0, 16'h0000, 16'hBEEF, 1, 0, 0);
    add("idle_after",  0, 0, 0, 16'h0000, 0, 16'h0000, 16'hBEEF, 0, 0, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].d);
      check_all(tbl[i].name, tbl[i].c, tbl[i].tos, tbl[i].pa, tbl[i].pv, tbl[i].ovf, tbl[i].udf);
    end

    // Fill to full, push once more to overflow, then swap while full.
    for (int i = 0; i < DP; i++) begin
      apply(1, 0, 0, 16'(i));
      check_all($sformatf("fill%0d", i), i + 1, 16'(i), 16'hBEEF, 0, 0, 0);
    end
    apply(1, 0, 0, 16'hDEAD);
    check_all("push_full", DP, 16'h000F, 16'hBEEF, 0, 1, 0);
    apply(0, 1, 0, 16'h0000);
    check_all("pop_after_ovf", DP - 1, 16'h000E, 16'h000F, 1, 1, 0);
    apply(1, 0, 0, 16'h000F);
    check_all("refill", DP, 16'h000F, 16'h000F, 0, 1, 0);
    apply(0, 0, 1, 16'h0000);
    check_all("clr_ovf", DP, 16'h000F, 16'h000F, 0, 0, 0);
    apply(1, 1, 0, 16'h1234);
    check_all("swap_full", DP, 16'h1234, 16'h000F, 1, 0, 0);
    apply(1, 0, 1, 16'h5555);
    check_all("clr_vs_ovf", DP, 16'h1234, 16'h000F, 0, 0, 0);

    // Randomized traffic checked against the queue model. Phases alternate
    // between push-heavy and pop-heavy mixes so both full and empty are reached.
    do_reset();
    m_q.delete();
    m_pa = '0; m_pv = 0; m_ovf = 0; m_udf = 0;
    for (int i = 0; i < 800; i++) begin
      logic p, q, c;
      logic [DW-1:0] d;
      int hi;
      hi = ((i / 100) % 2 == 0) ? 75 : 25;
      p = ($urandom_range(99) < hi);
      q = ($urandom_range(99) < (100 - hi));
      c = ($urandom_range(99) < 4);
      d = 16'($urandom);
      model_step(p, q, c, d);
      apply(p, q, c, d);
      mt = (m_q.size() > 0) ? m_q[$] : '0;
      check_all($sformatf("rand%0d", i), m_q.size(), mt, m_pa, m_pv, m_ovf, m_udf);
    end

    // Assert reset between clock edges in the middle of traffic.
    do_reset();
    for (int i = 0; i < 5; i++) apply(1, 0, 0, 16'h0010 + 16'(i));
    apply(0, 1, 0, 16'h0000);
    check_all("pre_reset", 4, 16'h0013, 16'h0014, 1, 0, 0);
    push = 1; pop = 0; stack_push_a = 16'h7777;
    #3;
    rst = 1'b1;
    #1;
    check_all("mid_reset", 0, 16'h0000, 16'h0000, 0, 0, 0);
    push = 0;
    @(negedge clk);
    rst = 1'b0;
    apply(0, 1, 0, 16'h0000);
    check_all("post_reset_pop", 0, 16'h0000, 16'h0000, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
